// File: rtl/prefix_sum_stage.sv
`default_nettype none
// ============================================================================
//  Module      : prefix_sum_stage
//  Description : Final stage of the mantissa prefix adder. Forms sum bits
//                and carry-out from group (G,P) pairs, then registers each
//                result into a small circular output buffer with a
//                valid/ready handshake toward the normaliser.
//  Options     : PSS_ZERO_FLAG_EN - store a per-entry sum==0 flag and drive
//                it on 'zero'; when undefined 'zero' is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefix_sum_stage #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0][1:0] grp,
    input  logic [WIDTH-1:0]      pbit,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic                  zero
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_push;
    logic             w_pop;

    logic [WIDTH-1:0]   r_sum_mem  [DEPTH];
    logic               r_cout_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Carry into bit i is the group generate of bits [i-1:0], or their group
    // propagate gating the external carry-in.
    assign w_carry[0] = cin;
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_carry
            assign w_carry[i] = grp[i-1][1] | (grp[i-1][0] & cin);
        end
    endgenerate

    assign w_sum  = pbit ^ w_carry;
    assign w_cout = grp[WIDTH-1][1] | (grp[WIDTH-1][0] & cin);

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign in_ready  = (r_count < c_DEPTH_CNT) | out_ready;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Head entry is always read from storage; nothing bypasses the buffer.
    assign sum  = r_sum_mem[r_rd_ptr];
    assign cout = r_cout_mem[r_rd_ptr];

    // Entry storage: written at the write pointer on push, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sum_mem[k]  <= '0;
                r_cout_mem[k] <= 1'b0;
            end
        end else if (w_push) begin
            r_sum_mem[r_wr_ptr]  <= w_sum;
            r_cout_mem[r_wr_ptr] <= w_cout;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PSS_ZERO_FLAG_EN
    logic r_zero_mem [DEPTH];

    // Exact-cancellation flag captured alongside each sum at push time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) r_zero_mem[k] <= 1'b0;
        end else if (w_push) begin
            r_zero_mem[r_wr_ptr] <= ~|w_sum;
        end
    end

    assign zero = r_zero_mem[r_rd_ptr];
`else
    assign zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefix_sum_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prefix_sum_stage
//  Description : Scoreboard bench for prefix_sum_stage. A driver pushes the
//                expected {zero,cout,sum} into a queue when an input is
//                accepted; a monitor pops and compares on each output pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prefix_sum_stage;

    localparam int c_W = 17;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [c_W-1:0][1:0] grp = '0;
    logic [c_W-1:0]      pbit = '0;
    logic                cin = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [c_W-1:0]      sum;
    logic                cout;
    logic                zero;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  rnd_ready = 1'b0;
    logic [c_W+1:0] exp_q [$];   // {zero, cout, sum}

    prefix_sum_stage #(.WIDTH(c_W), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .grp      (grp),
        .pbit     (pbit),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference prefix network: G[i:0], P[i:0] from bitwise generate/propagate.
    function automatic logic [c_W-1:0][1:0] prefix(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        logic [c_W-1:0][1:0] r;
        logic gg, pp;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < c_W; i++) begin
            gg = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
            pp = pp & (a[i] ^ b[i]);
            r[i] = {gg, pp};
        end
        return r;
    endfunction

    function automatic logic exp_zero(input logic [c_W-1:0] s);
`ifdef PSS_ZERO_FLAG_EN
        return (s == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Present one operand pair until accepted, queueing its expected result.
    task automatic send(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic ci,
                        input logic [c_W-1:0] esum, input logic ecout);
        bit done = 1'b0;
        int t = 0;
        grp = prefix(a, b);
        pbit = a ^ b;
        cin = ci;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                exp_q.push_back({exp_zero(esum), ecout, esum});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every output pop is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {14'd0, zero, cout, sum}, 32'hFFFF_FFFF);
            end else begin
                logic [c_W+1:0] e;
                e = exp_q.pop_front();
                chk("result", {14'd0, zero, cout, sum}, {14'd0, e});
            end
        end
    end

    // Random downstream stalls when enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(3) != 0);
    end

    initial begin
        logic [c_W-1:0] ra, rb;
        logic           rc;
        logic [c_W:0]   rs;
        int             t;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;

        // Reset mid-stream with two entries held
        out_ready = 1'b0;
        send(17'h00005, 17'h00003, 1'b0, 17'h00008, 1'b0);
        send(17'h00010, 17'h00001, 1'b1, 17'h00012, 1'b0);
        @(negedge clk);
        chk("held_full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_sum",  {15'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Carry ripples to bit 16, then full overflow to zero
        out_ready = 1'b1;
        send(17'h0FFFF, 17'h00001, 1'b0, 17'h10000, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        send(17'h1FFFF, 17'h00001, 1'b0, 17'h00000, 1'b1);
        send(17'h00000, 17'h00000, 1'b1, 17'h00001, 1'b0);
        send(17'h1FFFF, 17'h1FFFF, 1'b1, 17'h1FFFF, 1'b1);
        send(17'h15555, 17'h0AAAA, 1'b0, 17'h1FFFF, 1'b0);
        send(17'h15555, 17'h0AAAA, 1'b1, 17'h00000, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Stall: two accepts, third held until ready returns, order kept
        out_ready = 1'b0;
        fork
            begin
                send(17'h00100, 17'h00200, 1'b0, 17'h00300, 1'b0);
                send(17'h10000, 17'h10000, 1'b0, 17'h00000, 1'b1);
                send(17'h01234, 17'h04321, 1'b1, 17'h05556, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_head_sum", {15'd0, sum}, 32'h00300);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Full buffer with simultaneous push and pop, pointers wrap
        out_ready = 1'b0;
        send(17'h00001, 17'h00001, 1'b0, 17'h00002, 1'b0);
        send(17'h00002, 17'h00002, 1'b0, 17'h00004, 1'b0);
        out_ready = 1'b1;
        fork
            begin
                send(17'h00003, 17'h00003, 1'b0, 17'h00006, 1'b0);
                send(17'h00004, 17'h00004, 1'b0, 17'h00008, 1'b0);
                send(17'h00005, 17'h00005, 1'b0, 17'h0000A, 1'b0);
            end
            begin
                @(negedge clk);
                chk("full_pushpop_in_ready", {31'd0, in_ready}, 32'd1);
                @(negedge clk);
                chk("full_pushpop_out_valid", {31'd0, out_valid}, 32'd1);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Random operands with random downstream stalls
        rnd_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            ra = c_W'($urandom);
            rb = c_W'($urandom);
            rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {{c_W{1'b0}}, rc};
            send(ra, rb, rc, rs[c_W-1:0], rs[c_W]);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_queue_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
